c906_irq_ctrl: RTL and testbench

// - Interrupt conditioning stage directly upstream of the C906 core wrapper's xx_intc_int[39:0] PLIC input.
// - Per source: optional input synchronisation, edge/level selection, sticky pending latch, mask.
// - Registers are programmed over a zero-wait-state APB3 slave.
// - Output is the registered (pending & mask) vector, consumed as level interrupts by the core PLIC.

---
 rtl/c906_irq_pkg.sv | 24 ++
 rtl/c906_irq_if.sv | 24 ++
 rtl/c906_irq_sync.sv | 27 ++
 rtl/c906_irq_ctrl.sv | 140 ++++++++++++++
 tb/tb_c906_irq_ctrl.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/c906_irq_pkg.sv
// Shared constants and types for the C906 interrupt conditioning stage.
// Register offsets are the low 5 bits of the APB byte address.
package c906_irq_pkg;

  localparam int NUM_IRQ_DEF = 40;
  localparam int APB_AW_DEF  = 12;

  localparam logic [4:0] MASK_LO  = 5'h00;
  localparam logic [4:0] MASK_HI  = 5'h04;
  localparam logic [4:0] MODE_LO  = 5'h08;
  localparam logic [4:0] MODE_HI  = 5'h0C;
  localparam logic [4:0] PEND_LO  = 5'h10;
  localparam logic [4:0] PEND_HI  = 5'h14;
  localparam logic [4:0] RAW_LO   = 5'h18;
  localparam logic [4:0] RAW_HI   = 5'h1C;
  localparam logic [4:0] ADDR_MAX = 5'h1C;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/c906_irq_if.sv
// APB3 bus bundle for the interrupt conditioning stage.
// The slave modport is used by c906_irq_ctrl; the master side is the bus fabric.
interface c906_irq_apb_if #(
  parameter int APB_AW = 12
);
  logic              apb_psel;
  logic              apb_penable;
  logic              apb_pwrite;
  logic [APB_AW-1:0] apb_paddr;
  logic [31:0]       apb_pwdata;
  logic [31:0]       apb_prdata;
  logic              apb_pready;
  logic              apb_pslverr;

  modport slave (
    input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
    output apb_prdata, apb_pready, apb_pslverr
  );

  modport master (
    output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
    input  apb_prdata, apb_pready, apb_pslverr
  );
endinterface

// File: rtl/c906_irq_sync.sv
// Two-flop synchroniser bank for interrupt sources arriving from other clock domains.
// Only instantiated when C906_IRQ_SYNC_EN is defined.
module c906_irq_sync #(
  parameter int WIDTH = 40
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/c906_irq_ctrl.sv
// Interrupt conditioning for the C906 PLIC input: sync, edge/level select, sticky pending, mask.
// Define C906_IRQ_SYNC_EN to put a 2-flop synchroniser on every source.
//   state  | meaning
//   IDLE   | no transfer; prdata/pslverr held at 0
//   SETUP  | setup phase captured; response registered and driven during access phase
//   ACCESS | access phase completed; writes committed on this edge
module c906_irq_ctrl
  import c906_irq_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int APB_AW  = APB_AW_DEF
) (
  input  logic               pll_core_cpuclk,
  input  logic               pad_cpu_rst,
  input  logic [NUM_IRQ-1:0] irq_src,
  c906_irq_apb_if.slave      apb,
  output logic [NUM_IRQ-1:0] xx_intc_int
);

  localparam int HI_W = NUM_IRQ - 32;

  apb_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] mode_q, mode_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] hist_q;
  logic [NUM_IRQ-1:0] int_q;
  logic [NUM_IRQ-1:0] src_s;
  logic [NUM_IRQ-1:0] clr;
  logic [31:0]        prdata_q, prdata_d;
  logic               pslverr_q, pslverr_d;
  logic [31:0]        rd_word;
  logic               addr_err;
  logic               wr_commit;
  logic [63:0]        mask_x, mode_x, pend_x, raw_x;

`ifdef C906_IRQ_SYNC_EN
  c906_irq_sync #(.WIDTH(NUM_IRQ)) u_sync (
    .clk_i (pll_core_cpuclk),
    .rst_i (pad_cpu_rst),
    .d_i   (irq_src),
    .q_o   (src_s)
  );
`else
  assign src_s = irq_src;
`endif

  assign addr_err = (apb.apb_paddr > {{(APB_AW-5){1'b0}}, ADDR_MAX}) ||
                    (apb.apb_paddr[1:0] != 2'b00);

  always_comb begin
    state_d = IDLE;
    if (apb.apb_psel && !apb.apb_penable) begin
      state_d = SETUP;
    end else if (apb.apb_psel && apb.apb_penable && (state_q == SETUP)) begin
      state_d = ACCESS;
    end
  end

  assign wr_commit = (state_d == ACCESS) && apb.apb_pwrite && !addr_err;

  assign mask_x = 64'(mask_q);
  assign mode_x = 64'(mode_q);
  assign pend_x = 64'(pend_q);
  assign raw_x  = 64'(src_s);

  always_comb begin
    rd_word = '0;
    case (apb.apb_paddr[4:0])
      MASK_LO: rd_word = mask_x[31:0];
      MASK_HI: rd_word = mask_x[63:32];
      MODE_LO: rd_word = mode_x[31:0];
      MODE_HI: rd_word = mode_x[63:32];
      PEND_LO: rd_word = pend_x[31:0];
      PEND_HI: rd_word = pend_x[63:32];
      RAW_LO:  rd_word = raw_x[31:0];
      RAW_HI:  rd_word = raw_x[63:32];
      default: rd_word = '0;
    endcase
  end

  // Response is captured on the setup edge so it is stable for the whole access phase.
  always_comb begin
    prdata_d  = '0;
    pslverr_d = 1'b0;
    if (state_d == SETUP) begin
      pslverr_d = addr_err;
      if (!addr_err && !apb.apb_pwrite) begin
        prdata_d = rd_word;
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    clr    = '0;
    if (wr_commit) begin
      case (apb.apb_paddr[4:0])
        MASK_LO: mask_d = {mask_q[NUM_IRQ-1:32], apb.apb_pwdata};
        MASK_HI: mask_d = {apb.apb_pwdata[HI_W-1:0], mask_q[31:0]};
        MODE_LO: mode_d = {mode_q[NUM_IRQ-1:32], apb.apb_pwdata};
        MODE_HI: mode_d = {apb.apb_pwdata[HI_W-1:0], mode_q[31:0]};
        PEND_LO: clr    = {{HI_W{1'b0}}, apb.apb_pwdata};
        PEND_HI: clr    = {apb.apb_pwdata[HI_W-1:0], 32'h0};
        default: ;
      endcase
    end
    // Edge bits: new edge beats a same-cycle clear. Level bits just follow the source.
    pend_d = (mode_q & ((pend_q & ~clr) | (src_s & ~hist_q))) | (~mode_q & src_s);
  end

  always_ff @(posedge pll_core_cpuclk or posedge pad_cpu_rst) begin
    if (pad_cpu_rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      mode_q    <= '0;
      pend_q    <= '0;
      hist_q    <= '0;
      int_q     <= '0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      mode_q    <= mode_d;
      pend_q    <= pend_d;
      hist_q    <= src_s;
      int_q     <= pend_q & mask_q;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign apb.apb_prdata  = prdata_q;
  assign apb.apb_pslverr = pslverr_q;
  assign apb.apb_pready  = 1'b1;
  assign xx_intc_int     = int_q;

endmodule

// File: tb/tb_c906_irq_ctrl.sv
// Directed scoreboard bench for c906_irq_ctrl: APB responses and xx_intc_int transitions
// are queued by the stimulus and checked by independent monitors.
module tb_c906_irq_ctrl;

  localparam int NI = 40;
`ifdef C906_IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam int D1 = (LAT == 2) ? 1 : 0;
  localparam int D2 = D1 + LAT - 3;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    string       nm;
  } apb_exp_t;

  typedef struct {
    logic [NI-1:0] val;
    int            cyc;
    string         nm;
  } int_exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] irq_src = '0;
  logic [NI-1:0] xx_intc_int;
  logic [NI-1:0] int_last = '0;

  apb_exp_t apb_q[$];
  int_exp_t int_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  c906_irq_apb_if #(.APB_AW(12)) apb ();

  c906_irq_ctrl #(.NUM_IRQ(NI), .APB_AW(12)) dut (
    .pll_core_cpuclk (clk),
    .pad_cpu_rst     (rst),
    .irq_src         (irq_src),
    .apb             (apb),
    .xx_intc_int     (xx_intc_int)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // APB monitor: every access phase consumes one expected response.
  always @(negedge clk) begin
    apb_exp_t e;
    if (!rst && apb.apb_psel && apb.apb_penable) begin
      checks++;
      if (apb_q.size() == 0) begin
        errors++;
        $display("FAIL apb_unexpected: access at addr %h with no expectation queued", apb.apb_paddr);
      end else begin
        e = apb_q.pop_front();
        if (apb.apb_prdata !== e.rd || apb.apb_pslverr !== e.err || apb.apb_pready !== 1'b1) begin
          errors++;
          $display("FAIL %s: got prdata=%h pslverr=%b pready=%b, expected prdata=%h pslverr=%b pready=1",
                   e.nm, apb.apb_prdata, apb.apb_pslverr, apb.apb_pready, e.rd, e.err);
        end
      end
    end
  end

  // Interrupt monitor: every change of xx_intc_int must match the next queued value and cycle.
  always @(negedge clk) begin
    int_exp_t e;
    if (!rst && (xx_intc_int !== int_last)) begin
      checks++;
      if (int_q.size() == 0) begin
        errors++;
        $display("FAIL int_unexpected: xx_intc_int changed to %h at cycle %0d", xx_intc_int, cyc);
      end else begin
        e = int_q.pop_front();
        if (xx_intc_int !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL %s: got xx_intc_int=%h at cycle %0d, expected %h at cycle %0d",
                   e.nm, xx_intc_int, cyc, e.val, e.cyc);
        end
      end
      int_last = xx_intc_int;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic exp_int(input logic [NI-1:0] val, input int at, input string nm);
    int_exp_t e;
    e.val = val;
    e.cyc = at;
    e.nm  = nm;
    int_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the commit edge.
  task automatic apb_xfer(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee, input string nm);
    apb_exp_t e;
    e.rd  = er;
    e.err = ee;
    e.nm  = nm;
    apb_q.push_back(e);
    apb.apb_psel    = 1'b1;
    apb.apb_penable = 1'b0;
    apb.apb_pwrite  = wr;
    apb.apb_paddr   = a;
    apb.apb_pwdata  = wd;
    tick(1);
    apb.apb_penable = 1'b1;
    tick(1);
    apb.apb_psel    = 1'b0;
    apb.apb_penable = 1'b0;
    apb.apb_pwrite  = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] er, input string nm);
    apb_xfer(1'b0, a, 32'h0, er, 1'b0, nm);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] wd, input string nm);
    apb_xfer(1'b1, a, wd, 32'h0, 1'b0, nm);
  endtask

  initial begin
    apb.apb_psel    = 1'b0;
    apb.apb_penable = 1'b0;
    apb.apb_pwrite  = 1'b0;
    apb.apb_paddr   = '0;
    apb.apb_pwdata  = '0;

    // Reset state
    tick(3);
    check("reset_pready", 64'(apb.apb_pready), 64'h1);
    check("reset_int", 64'(xx_intc_int), 64'h0);
    check("reset_prdata", 64'(apb.apb_prdata), 64'h0);
    check("reset_pslverr", 64'(apb.apb_pslverr), 64'h0);
    rst = 1'b0;
    tick(2);
    rd(12'h000, 32'h0, "reset_mask_lo");
    rd(12'h00C, 32'h0, "reset_mode_hi");
    rd(12'h010, 32'h0, "reset_pend_lo");
    rd(12'h018, 32'h0, "reset_raw_lo");

    // Edge interrupt on source 0, then W1C
    wr(12'h000, 32'h1, "wr_mask_lo_1");
    wr(12'h008, 32'h1, "wr_mode_lo_1");
    tick(1);
    irq_src[0] = 1'b1;
    exp_int(40'h1, cyc + LAT, "edge_int0_rise");
    tick(1);
    irq_src[0] = 1'b0;
    tick(LAT + 2);
    rd(12'h010, 32'h1, "edge_pend_lo");
    exp_int(40'h0, cyc + 3, "w1c_int0_fall");
    wr(12'h010, 32'h1, "w1c_pend_lo_1");
    tick(2);

    // Level interrupt on source 39
    wr(12'h004, 32'h80, "wr_mask_hi_80");
    irq_src[39] = 1'b1;
    exp_int(40'h80_0000_0000, cyc + LAT, "level_int39_rise");
    tick(LAT + 2);
    wr(12'h014, 32'h80, "w1c_pend_hi_level");
    rd(12'h014, 32'h80, "level_pend_hi_kept");
    irq_src[39] = 1'b0;
    exp_int(40'h0, cyc + LAT, "level_int39_fall");
    tick(LAT + 2);

    // Edge on source 5 landing on the same edge as W1C of bit 5
    wr(12'h008, 32'h21, "wr_mode_lo_21");
    fork
      begin
        tick(D1);
        irq_src[5] = 1'b1;
      end
      begin
        tick(D2);
        wr(12'h010, 32'h20, "collision_w1c");
      end
    join
    rd(12'h010, 32'h20, "collision_pend_lo");
    irq_src[5] = 1'b0;
    tick(LAT);
    wr(12'h010, 32'h20, "w1c_pend_lo_20");
    rd(12'h010, 32'h0, "pend_lo_cleared");

    // Masked edge still latches; unmasking raises the output one clock after commit
    wr(12'h000, 32'h0, "wr_mask_lo_0");
    wr(12'h008, 32'h29, "wr_mode_lo_29");
    irq_src[3] = 1'b1;
    tick(1);
    irq_src[3] = 1'b0;
    tick(LAT + 2);
    rd(12'h010, 32'h8, "masked_pend_lo");
    exp_int(40'h8, cyc + 3, "unmask_int3_rise");
    wr(12'h000, 32'h8, "wr_mask_lo_8");

    // APB error responses
    apb_xfer(1'b0, 12'h020, 32'h0, 32'h0, 1'b1, "err_rd_0x20");
    check("pslverr_idle", 64'(apb.apb_pslverr), 64'h0);
    apb_xfer(1'b1, 12'h002, 32'hFFFF_FFFF, 32'h0, 1'b1, "err_wr_0x02");
    rd(12'h000, 32'h8, "mask_lo_unchanged");

    // Raw level readback and mixed edge/level pending
    irq_src = 40'hA5;
    tick(4);
    rd(12'h018, 32'hA5, "raw_lo_a5");
    rd(12'h01C, 32'h0, "raw_hi_0");
    rd(12'h010, 32'hAD, "pend_lo_mixed");

    // Unused HI bits read back as zero
    wr(12'h004, 32'hFFFF_FFFF, "wr_mask_hi_all");
    rd(12'h004, 32'hFF, "mask_hi_width");
    rd(12'h00C, 32'h0, "mode_hi_0");

    tick(LAT + 4);
    check("apb_queue_drained", 64'(apb_q.size()), 64'h0);
    check("int_queue_drained", 64'(int_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
